// File: rtl/gshare_predictor.sv
// gshare_predictor: IF-stage branch predictor made of a tagged BTB and a PHT
// of saturating counters, trained from the EX-stage resolution port.
// Optional feature macro: PREDICTOR_GSHARE_EN. When it is defined, a global
// history register is kept and XORed into the PHT index. When it is not
// defined, the build is a plain bimodal predictor.
// Prediction is combinational. Training, statistics and reset are synchronous.

module gshare_predictor #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 6,
  parameter int CTR_W   = 2,
  parameter int HIST_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_if,
  output logic              pre_jmp_status,
  output logic [ADDR_W-1:0] pre_jmp_target,
  output logic [HIST_W-1:0] pre_hist,
  input  logic [ADDR_W-1:0] pc_ex,
  input  logic              opt_is_jmp,
  input  logic [ADDR_W-1:0] ifjmp_target,
  input  logic              jmp_res,
  input  logic [HIST_W-1:0] ex_hist,
  input  logic              ex_pre_status,
  output logic [31:0]       br_count,
  output logic [31:0]       miss_count
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = ADDR_W - INDEX_W - 2;

  localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};
  // Weakly taken: MSB set, all other bits clear.
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b1, {(CTR_W-1){1'b0}}};

  // Word-aligned PC: bits [1:0] never take part in indexing or tagging.
  function automatic logic [INDEX_W-1:0] pc_index(input logic [ADDR_W-1:0] pc);
    return pc[INDEX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [ADDR_W-1:0] pc);
    return pc[ADDR_W-1:INDEX_W+2];
  endfunction

  // History occupies the low HIST_W bits of the index; the upper bits stay 0.
  function automatic logic [INDEX_W-1:0] hist_ext(input logic [HIST_W-1:0] h);
    logic [INDEX_W-1:0] r;
    r = {INDEX_W{1'b0}};
    r[HIST_W-1:0] = h;
    return r;
  endfunction

  // Saturating step: clamps at all-ones and at zero, never wraps.
  function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] c,
                                                input logic             up);
    logic [CTR_W-1:0] r;
    if (up) begin
      if (c == CTR_MAX) r = c;
      else              r = c + CTR_ONE;
    end else begin
      if (c == CTR_ZERO) r = c;
      else               r = c - CTR_ONE;
    end
    return r;
  endfunction

  logic              btb_valid_r  [ENTRIES];
  logic [TAG_W-1:0]  btb_tag_r    [ENTRIES];
  logic [ADDR_W-1:0] btb_target_r [ENTRIES];
  logic [CTR_W-1:0]  pht_r        [ENTRIES];

  logic [HIST_W-1:0]  if_hist_s;
  logic [HIST_W-1:0]  ex_hist_s;
  logic [INDEX_W-1:0] if_idx_s;
  logic [INDEX_W-1:0] if_pidx_s;
  logic [TAG_W-1:0]   if_tag_s;
  logic [INDEX_W-1:0] ex_idx_s;
  logic [INDEX_W-1:0] ex_pidx_s;
  logic [TAG_W-1:0]   ex_tag_s;
  logic               hit_s;
  logic               taken_s;
  logic               unused_s;

`ifdef PREDICTOR_GSHARE_EN
  logic [HIST_W-1:0] ghr_r;
  logic [HIST_W:0]   ghr_shift_s;

  // Concatenate then truncate so the shift also works for HIST_W == 1.
  assign ghr_shift_s = {ghr_r, jmp_res};
  assign if_hist_s   = ghr_r;
  assign ex_hist_s   = ex_hist;
  assign unused_s    = ^{pc_if[1:0], pc_ex[1:0], ghr_shift_s[HIST_W]};

  // Global history: shift in each resolved direction, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_r <= {HIST_W{1'b0}};
    end else if (opt_is_jmp) begin
      ghr_r <= ghr_shift_s[HIST_W-1:0];
    end else begin
      ghr_r <= ghr_r;
    end
  end
`else
  // Bimodal build: no history, so the PHT index reduces to the PC index.
  assign if_hist_s = {HIST_W{1'b0}};
  assign ex_hist_s = {HIST_W{1'b0}};
  assign unused_s  = ^{pc_if[1:0], pc_ex[1:0], ex_hist};
`endif

  // Index/tag decode for both the fetch and the resolve side.
  always_comb begin
    if_idx_s  = pc_index(pc_if);
    if_tag_s  = pc_tag(pc_if);
    if_pidx_s = if_idx_s ^ hist_ext(if_hist_s);
    ex_idx_s  = pc_index(pc_ex);
    ex_tag_s  = pc_tag(pc_ex);
    ex_pidx_s = ex_idx_s ^ hist_ext(ex_hist_s);
  end

  // Zero-latency prediction from old table contents; forced quiet in reset.
  always_comb begin
    hit_s   = btb_valid_r[if_idx_s] && (btb_tag_r[if_idx_s] == if_tag_s);
    taken_s = hit_s && pht_r[if_pidx_s][CTR_W-1];
    if (rst) begin
      pre_jmp_status = 1'b0;
      pre_jmp_target = {ADDR_W{1'b0}};
      pre_hist       = {HIST_W{1'b0}};
    end else begin
      pre_jmp_status = taken_s;
      pre_jmp_target = taken_s ? btb_target_r[if_idx_s] : {ADDR_W{1'b0}};
      pre_hist       = if_hist_s;
    end
  end

  // BTB valid bits: cleared by reset, set by every resolved branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) btb_valid_r[i] <= 1'b0;
    end else if (opt_is_jmp) begin
      btb_valid_r[ex_idx_s] <= 1'b1;
    end else begin
      btb_valid_r[ex_idx_s] <= btb_valid_r[ex_idx_s];
    end
  end

  // BTB tag/target payload: written regardless of direction, no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && opt_is_jmp) begin
      btb_tag_r[ex_idx_s]    <= ex_tag_s;
      btb_target_r[ex_idx_s] <= ifjmp_target;
    end else begin
      btb_tag_r[ex_idx_s]    <= btb_tag_r[ex_idx_s];
      btb_target_r[ex_idx_s] <= btb_target_r[ex_idx_s];
    end
  end

  // PHT training: weakly-taken on reset, saturating step toward the outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) pht_r[i] <= CTR_INIT;
    end else if (opt_is_jmp) begin
      pht_r[ex_pidx_s] <= ctr_next(pht_r[ex_pidx_s], jmp_res);
    end else begin
      pht_r[ex_pidx_s] <= pht_r[ex_pidx_s];
    end
  end

  // Performance counters: resolved branches and direction mispredicts.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count   <= 32'd0;
      miss_count <= 32'd0;
    end else if (opt_is_jmp) begin
      br_count <= br_count + 32'd1;
      if (ex_pre_status != jmp_res) miss_count <= miss_count + 32'd1;
      else                          miss_count <= miss_count;
    end else begin
      br_count   <= br_count;
      miss_count <= miss_count;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor. Stimulus pushes hand-computed expected
// outputs into a scoreboard queue; a monitor on the falling edge pops and
// compares whenever a check is flagged for that cycle.

module tb_gshare_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pc_if;
  logic        pre_jmp_status;
  logic [31:0] pre_jmp_target;
  logic [5:0]  pre_hist;
  logic [31:0] pc_ex;
  logic        opt_is_jmp;
  logic [31:0] ifjmp_target;
  logic        jmp_res;
  logic [5:0]  ex_hist;
  logic [5:0]  ex_hist_drv;
  logic        hist_loop;
  logic        ex_pre_status;
  logic [31:0] br_count;
  logic [31:0] miss_count;

  typedef struct {
    logic        st;
    logic [31:0] tgt;
    logic [5:0]  hist;
    logic [31:0] br;
    logic [31:0] miss;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  chk_en;
  int    n_checks;
  int    n_fail;

`ifdef PREDICTOR_GSHARE_EN
  localparam logic [31:0] PRE_BR   = 32'd12;
  localparam logic [31:0] PRE_MISS = 32'd4;
  localparam logic [5:0]  HIST_U   = 6'd21;
`else
  localparam logic [31:0] PRE_BR   = 32'd10;
  localparam logic [31:0] PRE_MISS = 32'd6;
  localparam logic [5:0]  HIST_U   = 6'd0;
`endif

  assign ex_hist = hist_loop ? pre_hist : ex_hist_drv;

  gshare_predictor dut (
    .clk           (clk),
    .rst           (rst),
    .pc_if         (pc_if),
    .pre_jmp_status(pre_jmp_status),
    .pre_jmp_target(pre_jmp_target),
    .pre_hist      (pre_hist),
    .pc_ex         (pc_ex),
    .opt_is_jmp    (opt_is_jmp),
    .ifjmp_target  (ifjmp_target),
    .jmp_res       (jmp_res),
    .ex_hist       (ex_hist),
    .ex_pre_status (ex_pre_status),
    .br_count      (br_count),
    .miss_count    (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare DUT outputs against the scoreboard head on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks = n_checks + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL scoreboard_underflow: output present but no expected entry");
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (pre_jmp_status !== e.st || pre_jmp_target !== e.tgt || pre_hist !== e.hist ||
            br_count !== e.br || miss_count !== e.miss) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: got st=%0d tgt=%h hist=%0d br=%0d miss=%0d, want st=%0d tgt=%h hist=%0d br=%0d miss=%0d",
                   nm, pre_jmp_status, pre_jmp_target, pre_hist, br_count, miss_count,
                   e.st, e.tgt, e.hist, e.br, e.miss);
        end
      end
    end
  end

  // Advance to just after the next rising edge and clear one-cycle strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    chk_en     = 1'b0;
    opt_is_jmp = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pce, input logic [31:0] tgt,
                     input logic res, input logic eps);
    opt_is_jmp    = 1'b1;
    pc_ex         = pce;
    ifjmp_target  = tgt;
    jmp_res       = res;
    ex_pre_status = eps;
  endtask

  task automatic expect_out(input string nm, input logic st, input logic [31:0] tgt,
                            input logic [5:0] hist, input logic [31:0] br,
                            input logic [31:0] miss);
    exp_t e;
    e.st   = st;
    e.tgt  = tgt;
    e.hist = hist;
    e.br   = br;
    e.miss = miss;
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_en = 1'b1;
  endtask

`ifdef PREDICTOR_GSHARE_EN
  // Alternating T/N on pc 0x100 with history fed back: per-step expectations.
  logic       g_st   [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [5:0] g_hist [12] = '{6'd0, 6'd1, 6'd2, 6'd5, 6'd10, 6'd21, 6'd42, 6'd21, 6'd42, 6'd21, 6'd42, 6'd21};
  logic [31:0] g_miss[12] = '{32'd0, 32'd1, 32'd2, 32'd2, 32'd3, 32'd3, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4};
`endif

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    chk_en        = 1'b0;
    hist_loop     = 1'b0;
    ex_hist_drv   = 6'd0;
    rst           = 1'b1;
    pc_if         = 32'h100;
    pc_ex         = 32'h0;
    opt_is_jmp    = 1'b0;
    ifjmp_target  = 32'h0;
    jmp_res       = 1'b0;
    ex_pre_status = 1'b0;

    tick();
    tick();
    tick(); pc_if = 32'h100; expect_out("rst_hold", 1'b0, 32'h0, 6'd0, 32'd0, 32'd0);
    tick(); rst = 1'b0; pc_if = 32'h100; expect_out("reset_state", 1'b0, 32'h0, 6'd0, 32'd0, 32'd0);

`ifdef PREDICTOR_GSHARE_EN
    for (int k = 0; k < 12; k++) begin
      tick();
      pc_if     = 32'h100;
      hist_loop = 1'b1;
      upd(32'h100, 32'h200, (k % 2) == 0, g_st[k]);
      expect_out($sformatf("gshare_alt_%0d", k), g_st[k], g_st[k] ? 32'h200 : 32'h0,
                 g_hist[k], k, g_miss[k]);
    end
    tick(); hist_loop = 1'b0;
`else
    tick(); upd(32'h100, 32'h200, 1'b1, 1'b0); expect_out("warm_same_cycle", 1'b0, 32'h0,   6'd0, 32'd0, 32'd0);
    tick(); upd(32'h100, 32'h200, 1'b1, 1'b1); expect_out("warm_taken",      1'b1, 32'h200, 6'd0, 32'd1, 32'd1);
    tick(); upd(32'h100, 32'h200, 1'b1, 1'b1); expect_out("sat_hi_1",        1'b1, 32'h200, 6'd0, 32'd2, 32'd1);
    tick(); upd(32'h100, 32'h200, 1'b0, 1'b1); expect_out("sat_hi_2",        1'b1, 32'h200, 6'd0, 32'd3, 32'd1);
    tick(); upd(32'h100, 32'h200, 1'b0, 1'b1); expect_out("not_taken_1",     1'b1, 32'h200, 6'd0, 32'd4, 32'd2);
    tick(); upd(32'h100, 32'h200, 1'b0, 1'b0); expect_out("not_taken_2",     1'b0, 32'h0,   6'd0, 32'd5, 32'd3);
    tick(); upd(32'h100, 32'h200, 1'b0, 1'b0); expect_out("sat_lo_1",        1'b0, 32'h0,   6'd0, 32'd6, 32'd3);
    tick(); upd(32'h100, 32'h200, 1'b1, 1'b0); expect_out("sat_lo_2",        1'b0, 32'h0,   6'd0, 32'd7, 32'd3);
    tick(); upd(32'h100, 32'h200, 1'b1, 1'b0); expect_out("sat_lo_3",        1'b0, 32'h0,   6'd0, 32'd8, 32'd4);
    tick(); expect_out("retrain", 1'b1, 32'h200, 6'd0, 32'd9, 32'd5);
    tick(); pc_if = 32'h100 + (32'd4 << 6); expect_out("tag_mismatch", 1'b0, 32'h0, 6'd0, 32'd9, 32'd5);
    tick(); pc_if = 32'h140; upd(32'h140, 32'h300, 1'b1, 1'b0);
    expect_out("hazard_same_cycle", 1'b0, 32'h0, 6'd0, 32'd9, 32'd5);
    tick(); pc_if = 32'h140; expect_out("hazard_next_cycle", 1'b1, 32'h300, 6'd0, 32'd10, 32'd6);
`endif

    // Reset with a simultaneous update: predictions quiet now, update dropped.
    tick(); rst = 1'b1; pc_if = 32'h140; upd(32'h180, 32'h380, 1'b1, 1'b0);
    expect_out("rst_forces_pred", 1'b0, 32'h0, 6'd0, PRE_BR, PRE_MISS);
    tick(); rst = 1'b0; pc_if = 32'h140; expect_out("rst_clears_btb", 1'b0, 32'h0, 6'd0, 32'd0, 32'd0);
    tick(); pc_if = 32'h180; expect_out("rst_drops_update", 1'b0, 32'h0, 6'd0, 32'd0, 32'd0);

    // Ten updates, mispredicts at steps 2, 5 and 7.
    for (int i = 0; i < 10; i++) begin
      logic r;
      tick();
      pc_if = 32'h0;
      r     = (i % 2) == 1;
      upd(32'h500 + 32'(4 * i), 32'h700, r, (i == 2 || i == 5 || i == 7) ? !r : r);
    end
    tick(); pc_if = 32'h0; expect_out("stats_10_3", 1'b0, 32'h0, HIST_U, 32'd10, 32'd3);
    tick(); upd(32'h600, 32'h700, 1'b1, 1'b0);
    tick(); rst = 1'b1; upd(32'h604, 32'h700, 1'b1, 1'b0);
    expect_out("stats_rst_cycle", 1'b0, 32'h0, 6'd0, 32'd11, 32'd4);
    tick(); rst = 1'b0; expect_out("stats_after_rst", 1'b0, 32'h0, 6'd0, 32'd0, 32'd0);

    tick();
    tick();
    n_checks = n_checks + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
